dmem_arbiter: RTL and testbench

- Shares the single data memory between the core load/store port and a DMA/loader port. Uses request/ready handshakes and round-robin arbitration.
- Sits between the core's memory stage (alu_result as address, rdata2 as store data, rd_en/wr_en from the control unit) and the data memory.
- core_ready is the core's stall-release: the PC holds while core_req is high and core_ready is low.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 20 ++
 rtl/dmem_arbiter_rr_pick2.sv | 29 ++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// dmem_arb_pkg : shared types and constants for the data-memory arbiter
// Revision     : 1.0
// ============================================================================
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DMA  = 1'b1
   } owner_t;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : request/ready memory access port (requester = master)
// Revision        : 1.0
// ============================================================================
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational two-way round-robin pick (core vs. DMA)
// Revision : 1.0
// ============================================================================
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  wire logic i_core_req,
   input  wire logic i_dma_req,
   input  owner_t    i_last_grant,
   output logic      o_valid,
   output owner_t    o_pick
);

   always_comb begin
      o_valid = i_core_req | i_dma_req;
      if (i_core_req && i_dma_req) begin
         // On a tie the port that was not served last wins.
         o_pick = (i_last_grant == OWN_CORE) ? OWN_DMA : OWN_CORE;
      end else if (i_dma_req) begin
         o_pick = OWN_DMA;
      end else begin
         o_pick = OWN_CORE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares one data memory between core and DMA ports.
//                Optional grant counters under DMEM_ARB_STATS_EN.
// Revision     : 1.0
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  wire logic          clk,
   input  wire logic          reset,
   dmem_arbiter_if.slave      core,
   dmem_arbiter_if.slave      dma,
   output logic               mem_rd_en,
   output logic               mem_wr_en,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  wire logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]   core_grants,
   output logic [CNT_W-1:0]   dma_grants
`endif
);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   owner_t        r_owner;
   owner_t        r_last_grant;
   owner_t        w_pick;
   logic          w_pick_valid;
   logic          w_grant;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;

   rr_pick2 u_pick (
      .i_core_req   (core.req),
      .i_dma_req    (dma.req),
      .i_last_grant (r_last_grant),
      .o_valid      (w_pick_valid),
      .o_pick       (w_pick)
   );

   assign w_grant = (r_state == IDLE) && w_pick_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner      <= OWN_CORE;
         r_last_grant <= OWN_DMA;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
      end else begin
         if (w_grant) begin
            r_owner      <= w_pick;
            r_last_grant <= w_pick;
            if (w_pick == OWN_CORE) begin
               r_we    <= core.we;
               r_addr  <= core.addr;
               r_wdata <= core.wdata;
            end else begin
               r_we    <= dma.we;
               r_addr  <= dma.addr;
               r_wdata <= dma.wdata;
            end
         end
         if (r_state == ACCESS) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      core.ready = 1'b0;
      core.rdata = '0;
      dma.ready  = 1'b0;
      dma.rdata  = '0;
      case (r_state)
         ACCESS: begin
            mem_rd_en = ~r_we;
            mem_wr_en = r_we;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
         end
         RESP: begin
            if (r_owner == OWN_CORE) begin
               core.ready = 1'b1;
               core.rdata = r_rdata;
            end else begin
               dma.ready = 1'b1;
               dma.rdata = r_rdata;
            end
         end
         default: ;
      endcase
   end

`ifdef DMEM_ARB_STATS_EN
   logic [CNT_W-1:0] r_core_grants;
   logic [CNT_W-1:0] r_dma_grants;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_core_grants <= '0;
         r_dma_grants  <= '0;
      end else if (w_grant) begin
         if (w_pick == OWN_CORE) begin
            r_core_grants <= sat_inc(r_core_grants);
         end else begin
            r_dma_grants <= sat_inc(r_dma_grants);
         end
      end
   end

   assign core_grants = r_core_grants;
   assign dma_grants  = r_dma_grants;
`endif

   // A requester must hold req from grant through its ready cycle.
   a_core_req_held: assert property (@(posedge clk) disable iff (reset)
      (r_state != IDLE && r_owner == OWN_CORE) |-> core.req);
   a_dma_req_held: assert property (@(posedge clk) disable iff (reset)
      (r_state != IDLE && r_owner == OWN_DMA) |-> dma.req);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed and randomized checks of dmem_arbiter against a
//                   transaction-level memory/arbitration model.
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   core_grants, dma_grants;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] phys    [0:63];
   logic [DW-1:0] ref_mem [0:63];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) core_bus ();
   dmem_arbiter_if #(.AW(AW), .DW(DW)) dma_bus ();

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .core      (core_bus),
      .dma       (dma_bus),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .core_grants (core_grants),
      .dma_grants  (dma_grants)
`endif
   );

   // Simple memory: combinational read, write on the rising edge.
   always @(posedge clk) if (mem_wr_en) phys[mem_addr[7:2]] <= mem_wdata;
   assign mem_rdata = mem_rd_en ? phys[mem_addr[7:2]] : '0;

   task automatic set_port(input int p, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         core_bus.req = req; core_bus.we = we; core_bus.addr = a; core_bus.wdata = d;
      end else begin
         dma_bus.req = req; dma_bus.we = we; dma_bus.addr = a; dma_bus.wdata = d;
      end
   endtask

   function automatic logic get_ready(input int p);
      return (p == 0) ? core_bus.ready : dma_bus.ready;
   endfunction

   function automatic logic [DW-1:0] get_rdata(input int p);
      return (p == 0) ? core_bus.rdata : dma_bus.rdata;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({core_bus.ready, dma_bus.ready, mem_rd_en, mem_wr_en} !== 4'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 0000",
                  {core_bus.ready, dma_bus.ready, mem_rd_en, mem_wr_en});
      end
      checks++;
      if ({core_bus.rdata, dma_bus.rdata, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_buses: got %h/%h/%h/%h expected all 0",
                  core_bus.rdata, dma_bus.rdata, mem_addr, mem_wdata);
      end
      reset = 1'b0;
   endtask

   task automatic test_core_store_load();
      logic [DW-1:0] v;
      for (int pass = 0; pass < 2; pass++) begin
         set_port(0, 1'b1, (pass == 0), 32'h10, 32'hDEADBEEF);
         @(negedge clk);
         checks++;
         if ({mem_wr_en, mem_rd_en, mem_addr} !== {(pass == 0), (pass != 0), 32'h10}) begin
            errors++;
            $display("FAIL core_strobe%0d: got wr=%b rd=%b addr=%h", pass, mem_wr_en, mem_rd_en, mem_addr);
         end
         if (pass == 0) begin
            checks++;
            if (mem_wdata !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL core_store_wdata: got %h expected deadbeef", mem_wdata);
            end
         end
         @(negedge clk);
         checks++;
         if ({core_bus.ready, dma_bus.ready} !== 2'b10) begin
            errors++;
            $display("FAIL core_ready%0d: got core=%b dma=%b expected 1/0", pass, core_bus.ready, dma_bus.ready);
         end
         if (pass == 1) begin
            v = core_bus.rdata;
            checks++;
            if (v !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL core_load_rdata: got %h expected deadbeef", v);
            end
         end
         @(negedge clk);
         set_port(0, 1'b0, 1'b0, '0, '0);
         checks++;
         if (core_bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL core_ready_pulse: got %b expected 0", core_bus.ready);
         end
      end
      ref_mem[4] = 32'hDEADBEEF;
   endtask

   task automatic test_tie();
      logic exp_c, exp_d;
      reset = 1'b1;
      set_port(0, 1'b1, 1'b1, 32'h20, 32'hA5A5_0001);
      set_port(1, 1'b1, 1'b1, 32'h24, 32'h5A5A_0002);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp_c = (k == 2) || (k == 8);
         exp_d = (k == 5) || (k == 11);
         checks++;
         if ({core_bus.ready, dma_bus.ready} !== {exp_c, exp_d}) begin
            errors++;
            $display("FAIL tie_order k=%0d: got core=%b dma=%b expected %b/%b",
                     k, core_bus.ready, dma_bus.ready, exp_c, exp_d);
         end
      end
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      ref_mem[8] = 32'hA5A5_0001;
      ref_mem[9] = 32'h5A5A_0002;
      @(negedge clk);
   endtask

   task automatic test_dma_back_to_back();
      logic [DW-1:0] d [0:3];
      int idx;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      set_port(1, 1'b1, 1'b1, 32'h0, d[0]);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         idx = k / 3;
         checks++;
         if (dma_bus.ready !== ((k % 3) == 2)) begin
            errors++;
            $display("FAIL dma_b2b_ready k=%0d: got %b expected %b", k, dma_bus.ready, ((k % 3) == 2));
         end
         if ((k % 3) == 1) begin
            checks++;
            if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 32'(idx * 4), d[idx]}) begin
               errors++;
               $display("FAIL dma_b2b_strobe k=%0d: got wr=%b addr=%h data=%h expected 1/%h/%h",
                        k, mem_wr_en, mem_addr, mem_wdata, idx * 4, d[idx]);
            end
         end
         if ((k % 3) == 0 && k < 12) set_port(1, 1'b1, 1'b1, 32'(idx * 4), d[idx]);
      end
      set_port(1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) ref_mem[i] = d[i];
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      set_port(0, 1'b1, 1'b0, 32'h10, '0);
      @(negedge clk);
      checks++;
      if (mem_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_access: got rd=%b expected 1", mem_rd_en);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({core_bus.ready, dma_bus.ready, mem_rd_en, mem_wr_en, mem_addr} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got ready=%b/%b rd=%b wr=%b addr=%h expected 0",
                  core_bus.ready, dma_bus.ready, mem_rd_en, mem_wr_en, mem_addr);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({core_bus.ready, mem_rd_en, mem_addr} !== {1'b0, 1'b1, 32'h10}) begin
         errors++;
         $display("FAIL rst_mid_regrant: got ready=%b rd=%b addr=%h expected 0/1/10",
                  core_bus.ready, mem_rd_en, mem_addr);
      end
      @(negedge clk);
      checks++;
      if ({core_bus.ready, core_bus.rdata} !== {1'b1, ref_mem[4]}) begin
         errors++;
         $display("FAIL rst_mid_ready: got ready=%b rdata=%h expected 1/%h",
                  core_bus.ready, core_bus.rdata, ref_mem[4]);
      end
      @(negedge clk);
      set_port(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
   endtask

   task automatic drive_port(input int p, input int n);
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          prev_wr, prev_rd, done;
      logic [AW-1:0] prev_addr;
      logic [DW-1:0] prev_wdata;
      int            start, lat, idle;
      for (int t = 0; t < n; t++) begin
         we = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 15) * 4);
         d  = $urandom;
         set_port(p, 1'b1, we, a, d);
         start = cyc;
         done  = 1'b0;
         prev_wr = 1'b0; prev_rd = 1'b0; prev_addr = '0; prev_wdata = '0;
         for (int w = 0; w < 20 && !done; w++) begin
            @(negedge clk);
            if (get_ready(p)) begin
               done = 1'b1;
               lat  = cyc - start;
               checks++;
               if (lat < 2 || lat > 5) begin
                  errors++;
                  $display("FAIL rand_latency p%0d: got %0d cycles expected 2..5", p, lat);
               end
               checks++;
               if ({prev_wr, prev_rd, prev_addr} !== {we, ~we, a} || (we && prev_wdata !== d)) begin
                  errors++;
                  $display("FAIL rand_strobe p%0d: got wr=%b rd=%b addr=%h data=%h expected %b/%b/%h/%h",
                           p, prev_wr, prev_rd, prev_addr, prev_wdata, we, ~we, a, d);
               end
               checks++;
               if (get_ready(1 - p) !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_both_ready p%0d: got other ready=1 expected 0", p);
               end
               if (we) begin
                  ref_mem[a[7:2]] = d;
               end else begin
                  checks++;
                  if (get_rdata(p) !== ref_mem[a[7:2]]) begin
                     errors++;
                     $display("FAIL rand_rdata p%0d addr=%h: got %h expected %h",
                              p, a, get_rdata(p), ref_mem[a[7:2]]);
                  end
               end
            end else begin
               prev_wr = mem_wr_en; prev_rd = mem_rd_en;
               prev_addr = mem_addr; prev_wdata = mem_wdata;
            end
         end
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout p%0d: got no ready within 20 cycles expected ready", p);
         end
         idle = $urandom_range(0, 2);
         @(negedge clk);
         if (idle > 0) begin
            set_port(p, 1'b0, 1'b0, '0, '0);
            repeat (idle - 1) @(negedge clk);
         end
      end
      set_port(p, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_random();
      fork
         drive_port(0, 40);
         drive_port(1, 40);
      join
      repeat (3) @(negedge clk);
   endtask

`ifdef DMEM_ARB_STATS_EN
   task automatic run_txn(input int p, input logic [AW-1:0] a);
      logic got;
      set_port(p, 1'b1, 1'b0, a, '0);
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk);
         got = get_ready(p);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL stats_timeout p%0d: got no ready expected ready", p);
      end
      @(negedge clk);
      set_port(p, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_stats();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) run_txn(0, 32'(i * 4));
      for (int i = 0; i < 2; i++) run_txn(1, 32'(i * 4));
      checks++;
      if ({core_grants, dma_grants} !== {16'd3, 16'd2}) begin
         errors++;
         $display("FAIL stats_count: got core=%0d dma=%0d expected 3/2", core_grants, dma_grants);
      end
      force dut.r_core_grants = 16'hFFFF;
      @(negedge clk);
      release dut.r_core_grants;
      run_txn(0, 32'h0);
      checks++;
      if (core_grants !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_saturate: got %h expected ffff", core_grants);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) begin
         phys[i]    = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b1;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      test_reset();
      test_core_store_load();
      test_tie();
      test_dma_back_to_back();
      test_reset_mid();
      test_random();
`ifdef DMEM_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
